// File: rtl/lsu_pkg.sv
// Size encodings, FSM states and lane helpers for the load/store memory port.
// The split-access states exist only when LSU_MISALIGN_SPLIT_EN is defined.
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_R = 2'b11;

`ifdef LSU_MISALIGN_SPLIT_EN
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD_WAIT = 2'd1,
      ST_LOAD_HI   = 2'd2,
      ST_STORE_HI  = 2'd3
   } lsu_state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD_WAIT = 2'd1
   } lsu_state_t;
`endif

   // Bits [3:0] are the lanes of the addressed word, bits [7:4] spill into the next word.
   function automatic logic [7:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
      logic [7:0] base;
      case (size)
         SZ_B:    base = 8'h01;
         SZ_H:    base = 8'h03;
         SZ_W:    base = 8'h0F;
         default: base = 8'h00;
      endcase
      return base << off;
   endfunction

   function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [1:0] size,
                                               input logic [1:0] off);
      logic [31:0] repl;
      case (size)
         SZ_B:    repl = {4{wdata[7:0]}};
         SZ_H:    repl = {2{wdata[15:0]}};
         default: repl = wdata;
      endcase
      // Rotating by the offset is a no-op for aligned data and places misaligned bytes correctly.
      return 32'(({repl, repl} << {off, 3'b000}) >> 32);
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic is_unsigned);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {off, 3'b000};
      case (size)
         SZ_B:    res = {{24{~is_unsigned & sh[7]}}, sh[7:0]};
         SZ_H:    res = {{16{~is_unsigned & sh[15]}}, sh[15:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: lane select, sign/zero extension, and merge of a
// word-crossing access from the captured low word and the current high word.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] cur_word,
   input  logic [31:0] lo_word,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic        split,
   output logic [31:0] data
);

   logic [31:0] merged;

   always_comb begin
      merged = cur_word;
      data   = '0;
      if (split) begin
         merged = 32'({cur_word, lo_word} >> {off, 3'b000});
         data   = load_extend(merged, 2'b00, size, is_unsigned);
      end else begin
         data   = load_extend(merged, off, size, is_unsigned);
      end
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator driving a word-addressed, byte-enabled synchronous data memory.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses instead of flagging them.
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter int RESET_PC_UNUSED = 0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_error,
   output logic              mem_read_ready,
   output logic [29:0]       mem_read_address,
   input  logic [31:0]       mem_read_data,
   output logic              mem_write_ready,
   output logic [29:0]       mem_write_address,
   output logic [31:0]       mem_write_data,
   output logic [3:0]        mem_write_byte
);

   lsu_state_t  state_reg, state_next;
   logic [1:0]  off_reg, off_next;
   logic [1:0]  size_reg, size_next;
   logic        uns_reg, uns_next;
   logic        rsp_valid_reg, rsp_valid_next;
   logic        rsp_error_reg, rsp_error_next;
   logic [31:0] rsp_rdata_reg, rsp_rdata_next;

   logic [29:0] req_word;
   logic [7:0]  req_be;
   logic [31:0] req_lanes;
   logic        req_err;
   logic        accept;
   logic        split_cur;
   logic [31:0] lo_word;
   logic [31:0] load_data;

   assign req_word  = 30'(req_addr[ADDR_W-1:2]);
   assign req_be    = byte_enable(req_size, req_addr[1:0]);
   assign req_lanes = store_lanes(req_wdata, req_size, req_addr[1:0]);

`ifdef LSU_MISALIGN_SPLIT_EN
   logic        split_reg, split_next;
   logic [29:0] hi_addr_reg, hi_addr_next;
   logic [31:0] hi_wdata_reg, hi_wdata_next;
   logic [3:0]  hi_be_reg, hi_be_next;
   logic [31:0] lo_data_reg, lo_data_next;
   logic        req_split;

   assign req_split = |req_be[7:4];
   assign req_err   = (req_size == SZ_R);
   assign split_cur = split_reg;
   assign lo_word   = lo_data_reg;
`else
   logic unused_hi_be;

   assign unused_hi_be = ^req_be[7:4];
   assign req_err      = (req_size == SZ_R) ||
                         ((req_size == SZ_H) && req_addr[0]) ||
                         ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
   assign split_cur    = 1'b0;
   assign lo_word      = '0;
`endif

   lsu_load_align u_align (
      .cur_word    (mem_read_data),
      .lo_word     (lo_word),
      .off         (off_reg),
      .size        (size_reg),
      .is_unsigned (uns_reg),
      .split       (split_cur),
      .data        (load_data)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg     <= ST_IDLE;
         off_reg       <= '0;
         size_reg      <= '0;
         uns_reg       <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_error_reg <= 1'b0;
         rsp_rdata_reg <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
         split_reg     <= 1'b0;
         hi_addr_reg   <= '0;
         hi_wdata_reg  <= '0;
         hi_be_reg     <= '0;
         lo_data_reg   <= '0;
`endif
      end else begin
         state_reg     <= state_next;
         off_reg       <= off_next;
         size_reg      <= size_next;
         uns_reg       <= uns_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_error_reg <= rsp_error_next;
         rsp_rdata_reg <= rsp_rdata_next;
`ifdef LSU_MISALIGN_SPLIT_EN
         split_reg     <= split_next;
         hi_addr_reg   <= hi_addr_next;
         hi_wdata_reg  <= hi_wdata_next;
         hi_be_reg     <= hi_be_next;
         lo_data_reg   <= lo_data_next;
`endif
      end
   end

   always_comb begin
      state_next        = state_reg;
      off_next          = off_reg;
      size_next         = size_reg;
      uns_next          = uns_reg;
      rsp_valid_next    = 1'b0;
      rsp_error_next    = 1'b0;
      rsp_rdata_next    = '0;
      mem_read_ready    = 1'b0;
      mem_read_address  = '0;
      mem_write_ready   = 1'b0;
      mem_write_address = '0;
      mem_write_data    = '0;
      mem_write_byte    = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_next        = split_reg;
      hi_addr_next      = hi_addr_reg;
      hi_wdata_next     = hi_wdata_reg;
      hi_be_next        = hi_be_reg;
      lo_data_next      = lo_data_reg;
`endif
      // Gating with resetn drops the strobes in the very cycle reset is asserted.
      req_ready = (state_reg == ST_IDLE) && resetn;
      accept    = req_valid && req_ready;

      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               off_next  = req_addr[1:0];
               size_next = req_size;
               uns_next  = req_unsigned;
               if (req_err) begin
                  rsp_valid_next = 1'b1;
                  rsp_error_next = 1'b1;
               end else if (req_write) begin
                  mem_write_ready   = 1'b1;
                  mem_write_address = req_word;
                  mem_write_data    = req_lanes;
                  mem_write_byte    = req_be[3:0];
`ifdef LSU_MISALIGN_SPLIT_EN
                  if (req_split) begin
                     hi_addr_next  = req_word + 30'd1;
                     hi_wdata_next = req_lanes;
                     hi_be_next    = req_be[7:4];
                     state_next    = ST_STORE_HI;
                  end else begin
                     rsp_valid_next = 1'b1;
                  end
`else
                  rsp_valid_next = 1'b1;
`endif
               end else begin
                  mem_read_ready   = 1'b1;
                  mem_read_address = req_word;
                  state_next       = ST_LOAD_WAIT;
`ifdef LSU_MISALIGN_SPLIT_EN
                  split_next   = req_split;
                  hi_addr_next = req_word + 30'd1;
                  if (req_split) begin
                     state_next = ST_LOAD_HI;
                  end
`endif
               end
            end
         end
         ST_LOAD_WAIT: begin
            rsp_valid_next = 1'b1;
            rsp_rdata_next = load_data;
            state_next     = ST_IDLE;
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         ST_LOAD_HI: begin
            lo_data_next     = mem_read_data;
            mem_read_ready   = 1'b1;
            mem_read_address = hi_addr_reg;
            state_next       = ST_LOAD_WAIT;
         end
         ST_STORE_HI: begin
            mem_write_ready   = 1'b1;
            mem_write_address = hi_addr_reg;
            mem_write_data    = hi_wdata_reg;
            mem_write_byte    = hi_be_reg;
            rsp_valid_next    = 1'b1;
            state_next        = ST_IDLE;
         end
`endif
         default: state_next = ST_IDLE;
      endcase
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_error = rsp_error_reg;
   assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a behavioural 1-cycle-latency byte-enabled memory.
// Split-access vectors are used when LSU_MISALIGN_SPLIT_EN is defined.
module tb_lsu_mem_port;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic        mem_read_ready;
   logic [29:0] mem_read_address;
   logic [31:0] mem_read_data;
   logic        mem_write_ready;
   logic [29:0] mem_write_address;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_write_byte;

   logic [31:0] mem [0:255];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   lsu_mem_port dut (
      .clk               (clk),
      .resetn            (resetn),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_write         (req_write),
      .req_size          (req_size),
      .req_unsigned      (req_unsigned),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .rsp_valid         (rsp_valid),
      .rsp_rdata         (rsp_rdata),
      .rsp_error         (rsp_error),
      .mem_read_ready    (mem_read_ready),
      .mem_read_address  (mem_read_address),
      .mem_read_data     (mem_read_data),
      .mem_write_ready   (mem_write_ready),
      .mem_write_address (mem_write_address),
      .mem_write_data    (mem_write_data),
      .mem_write_byte    (mem_write_byte)
   );

   always @(posedge clk) begin
      if (mem_read_ready) mem_read_data <= mem[mem_read_address[7:0]];
      if (mem_write_ready) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_write_byte[b]) mem[mem_write_address[7:0]][b*8 +: 8] <= mem_write_data[b*8 +: 8];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
   endtask

   task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_data, input logic [3:0] exp_be);
      drive(1'b1, sz, 1'b0, addr, wd);
      @(negedge clk);
      check({tag, ".wr"}, mem_write_ready, 1);
      check({tag, ".rd"}, mem_read_ready, 0);
      check({tag, ".wa"}, mem_write_address, addr >> 2);
      check({tag, ".wd"}, mem_write_data, exp_data);
      check({tag, ".be"}, mem_write_byte, exp_be);
      next_cycle();
      req_valid = 1'b0;
      @(negedge clk);
      check({tag, ".rv"}, rsp_valid, 1);
      check({tag, ".re"}, rsp_error, 0);
      check({tag, ".rz"}, rsp_rdata, 0);
      next_cycle();
      $display("store %s addr=%h data=%h done", tag, addr, wd);
   endtask

   task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] exp);
      drive(1'b0, sz, uns, addr, 32'h0);
      @(negedge clk);
      check({tag, ".rd"}, mem_read_ready, 1);
      check({tag, ".ra"}, mem_read_address, addr >> 2);
      check({tag, ".wr"}, mem_write_ready, 0);
      next_cycle();
      req_valid = 1'b0;
      @(negedge clk);
      check({tag, ".busy"}, {rsp_valid, req_ready}, 0);
      next_cycle();
      @(negedge clk);
      check({tag, ".rv"}, rsp_valid, 1);
      check({tag, ".data"}, rsp_rdata, exp);
      check({tag, ".re"}, rsp_error, 0);
      next_cycle();
      $display("load %s addr=%h data=%h", tag, addr, rsp_rdata);
   endtask

   task automatic do_error(input string tag, input logic wr, input logic [1:0] sz, input logic [31:0] addr);
      drive(wr, sz, 1'b0, addr, 32'h5A5A5A5A);
      @(negedge clk);
      check({tag, ".strobes"}, {mem_read_ready, mem_write_ready}, 0);
      next_cycle();
      req_valid = 1'b0;
      @(negedge clk);
      check({tag, ".rv"}, rsp_valid, 1);
      check({tag, ".re"}, rsp_error, 1);
      check({tag, ".rz"}, rsp_rdata, 0);
      next_cycle();
      $display("error %s addr=%h size=%b", tag, addr, sz);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      resetn = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset.rv", rsp_valid, 0);
      check("reset.re", rsp_error, 0);
      check("reset.rdata", rsp_rdata, 0);
      check("reset.strobes", {mem_read_ready, mem_write_ready}, 0);
      check("reset.wa", mem_write_address, 0);
      check("reset.be", mem_write_byte, 0);
      @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      check("reset.ready", req_ready, 1);
      $display("reset released");
      next_cycle();

      do_store("sw", 2'b10, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111);
      do_store("sb", 2'b00, 32'h103, 32'h12345678, 32'h78787878, 4'b1000);
      do_load("lw_after_sb", 2'b10, 1'b0, 32'h100, 32'h78ADBEEF);
      do_store("sw2", 2'b10, 32'h100, 32'h80017FFF, 32'h80017FFF, 4'b1111);
      do_load("lbu", 2'b00, 1'b1, 32'h103, 32'h00000080);
      do_load("lb", 2'b00, 1'b0, 32'h103, 32'hFFFFFF80);
      do_load("lh", 2'b01, 1'b0, 32'h102, 32'hFFFF8001);
      do_load("lhu", 2'b01, 1'b1, 32'h100, 32'h00007FFF);
      do_load("lb0", 2'b00, 1'b0, 32'h100, 32'hFFFFFFFF);
      do_load("lbu1", 2'b00, 1'b1, 32'h101, 32'h0000007F);
      do_store("sh", 2'b01, 32'h102, 32'hABCD1234, 32'h12341234, 4'b1100);
      do_load("lw_after_sh", 2'b10, 1'b0, 32'h100, 32'h12347FFF);
      do_error("size11_ld", 1'b0, 2'b11, 32'h104);
      do_error("size11_st", 1'b1, 2'b11, 32'h104);

      do_store("sw_lo", 2'b10, 32'h100, 32'h44332211, 32'h44332211, 4'b1111);
      do_store("sw_hi", 2'b10, 32'h104, 32'h88776655, 32'h88776655, 4'b1111);
`ifdef LSU_MISALIGN_SPLIT_EN
      drive(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
      @(negedge clk);
      check("lw_split.rd0", mem_read_ready, 1);
      check("lw_split.ra0", mem_read_address, 32'h40);
      next_cycle();
      req_valid = 1'b0;
      @(negedge clk);
      check("lw_split.rd1", mem_read_ready, 1);
      check("lw_split.ra1", mem_read_address, 32'h41);
      check("lw_split.ready", req_ready, 0);
      next_cycle();
      @(negedge clk);
      check("lw_split.wait", rsp_valid, 0);
      next_cycle();
      @(negedge clk);
      check("lw_split.rv", rsp_valid, 1);
      check("lw_split.data", rsp_rdata, 32'h55443322);
      check("lw_split.re", rsp_error, 0);
      next_cycle();
      $display("load lw_split addr=00000101 data=%h", rsp_rdata);

      do_load("lh_inword", 2'b01, 1'b0, 32'h101, 32'h00003322);

      drive(1'b1, 2'b10, 1'b0, 32'h103, 32'hAABBCCDD);
      @(negedge clk);
      check("sw_split.wa0", mem_write_address, 32'h40);
      check("sw_split.wd0", mem_write_data, 32'hDDAABBCC);
      check("sw_split.be0", mem_write_byte, 4'b1000);
      next_cycle();
      req_valid = 1'b0;
      @(negedge clk);
      check("sw_split.wr1", mem_write_ready, 1);
      check("sw_split.wa1", mem_write_address, 32'h41);
      check("sw_split.be1", mem_write_byte, 4'b0111);
      check("sw_split.early", rsp_valid, 0);
      next_cycle();
      @(negedge clk);
      check("sw_split.rv", rsp_valid, 1);
      next_cycle();
      $display("store sw_split addr=00000103 data=aabbccdd done");
      do_load("lw_w40", 2'b10, 1'b0, 32'h100, 32'hDD332211);
      do_load("lw_w41", 2'b10, 1'b0, 32'h104, 32'h88AABBCC);
`else
      do_error("lw_mis", 1'b0, 2'b10, 32'h101);
      do_error("lh_mis", 1'b0, 2'b01, 32'h101);
      do_error("sw_mis", 1'b1, 2'b10, 32'h102);
      do_load("lw_unchanged", 2'b10, 1'b0, 32'h104, 32'h88776655);
`endif

      // Back-to-back store then load of the same word in consecutive cycles.
      drive(1'b1, 2'b10, 1'b0, 32'h108, 32'hCAFEF00D);
      next_cycle();
      drive(1'b0, 2'b10, 1'b0, 32'h108, 32'h0);
      @(negedge clk);
      check("b2b.st_rv", rsp_valid, 1);
      check("b2b.ready", req_ready, 1);
      check("b2b.rd", mem_read_ready, 1);
      next_cycle();
      req_valid = 1'b0;
      next_cycle();
      @(negedge clk);
      check("b2b.ld_rv", rsp_valid, 1);
      check("b2b.ld_data", rsp_rdata, 32'hCAFEF00D);
      next_cycle();
      $display("b2b sw/lw addr=00000108 data=%h", rsp_rdata);

      // Reset asserted while waiting on load data.
      drive(1'b0, 2'b10, 1'b0, 32'h108, 32'h0);
      next_cycle();
      req_valid = 1'b0;
      check("rst_mid.busy", req_ready, 0);
      resetn = 1'b0;
      #1;
      check("rst_mid.strobes", {mem_read_ready, mem_write_ready}, 0);
      check("rst_mid.rv0", rsp_valid, 0);
      next_cycle();
      check("rst_mid.rv1", rsp_valid, 0);
      next_cycle();
      resetn = 1'b1;
      @(negedge clk);
      check("rst_mid.rv2", rsp_valid, 0);
      check("rst_mid.idle", req_ready, 1);
      next_cycle();
      @(negedge clk);
      check("rst_mid.rv3", rsp_valid, 0);
      $display("reset during load_wait handled");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store initiator that drives the word-addressed, byte-enabled synchronous data memory from the core's load/store stage.
- Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into:
  - a word address;
  - lane-replicated write data;
  - byte enables.
- Returns aligned, sign- or zero-extended load data, or an error flag.
- Sits between the execute/memory pipeline stage and the data memory, which has a 1-cycle read latency.

Parameters:
- ADDR_W, 32, byte-address width of req_addr.
- RESET_PC_UNUSED, 0, reserved, must stay 0 (no function).

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  zero-extend load (LBU/LHU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  formatted load data (0 for stores/errors).
- rsp_error  out  1  misaligned or reserved-size request; no memory access made.
- mem_read_ready  out  1  memory read strobe.
- mem_read_address  out  30  word address [31:2].
- mem_read_data  in  32  valid the cycle after mem_read_ready.
- mem_write_ready  out  1  memory write strobe.
- mem_write_address  out  30  word address [31:2].
- mem_write_data  out  32  lane-replicated store data.
- mem_write_byte  out  4  byte enables.

Behaviour:
- Clock and reset: one clock, clk; reset resetn is asynchronous, active-low.
- Reset values:
  - state IDLE;
  - rsp_valid, rsp_error = 0; rsp_rdata = 0;
  - mem strobes = 0; addresses, wdata and byte enables = 0.
- Reset asserted mid-operation aborts immediately. No response pulse; strobes drop in the same cycle.
- States: IDLE, LOAD_WAIT, plus LOAD_HI and STORE_HI with the optional feature.
- req_ready = 1 only in IDLE.
- In the accept cycle T, the memory strobe, address, data and byte enables are driven combinationally from the request.
- Never assert mem_read_ready and mem_write_ready together.
- Store:
  - Byte: wdata[7:0] replicated into 4 lanes; byte enable = 0001 << addr[1:0].
  - Half: {2{wdata[15:0]}}; byte enable = 0011 << addr[1:0].
  - Word: wdata; byte enable = 1111.
  - rsp_valid at T+1; state stays IDLE, so a new request is accepted at T+1.
- Load:
  - T: mem_read_ready = 1; go to LOAD_WAIT.
  - T+1: select the byte/half by addr[1:0], extend per req_unsigned, register; return to IDLE.
  - T+2: rsp_valid = 1 with the data; a new request may be accepted in the same cycle.
- The registered copies of addr[1:0], size and unsigned are captured at accept.
- Error (without the feature): half with addr[0] = 1, word with addr[1:0] != 0, or size 11.
  - No strobe is raised.
  - rsp_valid = rsp_error = 1 at T+1; rsp_rdata = 0.
- rsp_valid is a one-cycle pulse with no backpressure. rsp_error is valid only with rsp_valid.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined:
  - A request whose bytes fit in one word (addr[1:0] + nbytes <= 4) is done as a single access. Example: half at offset 1.
  - A request that crosses a word boundary is split in two:
    - low word addr[31:2];
    - high word addr[31:2] + 1, wrapping modulo 2^30.
  - Split store: T writes the low lanes; STORE_HI at T+1 writes the high lanes (enables for bytes 0..k-1); rsp at T+2.
  - Split load: T reads low; LOAD_HI at T+1 captures low data and reads high; T+2 merges and extends; rsp at T+3.
  - Only size 11 flags rsp_error.
- Undefined: alignment errors as described under Behaviour; LOAD_HI and STORE_HI are absent.

Decomposition:
- Package lsu_pkg:
  - size encodings SZ_B/SZ_H/SZ_W;
  - state enum;
  - function byte_enable(size, off);
  - function load_extend(word, off, size, unsigned).
- One natural sub-module: lsu_load_align, a combinational lane select, extend and split-merge unit.

Test Plan:
- SW 0xDEADBEEF @0x100 → T: mem_write_address 0x40, mem_write_byte 1111; rsp_valid at T+1, rsp_error 0.
- SB 0x12345678 @0x103 → mem_write_data 0x78787878, mem_write_byte 1000.
  - LBU @0x103 after memory holds 0x80xxxxxx → rsp_rdata 0x00000080 at T+2.
  - LB @0x103 → rsp_rdata 0xFFFFFF80.
- LH @0x102, memory word 0x8001_7FFF → rsp_rdata 0xFFFF8001. LHU @0x100 → 0x00007FFF.
- LW @0x101:
  - Feature off: no strobe; rsp_valid + rsp_error at T+1.
  - Feature on, words 0x44332211 / 0x88776655 → reads 0x40 then 0x41; rsp_rdata 0x55443322 at T+3.
- Back-to-back: SW then LW accepted in consecutive cycles → LW data reflects the store. Reset during LOAD_WAIT → no rsp_valid, state IDLE.
- Size 11 request → rsp_error in both builds; no memory strobe.
